// File: rtl/seg_pkg.sv
// seg_pkg: segment lookup and blanking constants shared by the scanner.
package seg_pkg;
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  localparam logic [7:0] SEG_OFF = 8'hFF;
  function automatic logic [7:0] wei_off(int n);
    return 8'((1 << n) - 1);
  endfunction
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: nibble to active-low a..g segment code.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_HEX[nib][6:0];
endmodule

// File: rtl/seg_scan_n.sv
// seg_scan_n: multiplexed common-anode 7-segment scanner with per-frame
// input snapshot, blanking, blinking, leading-zero suppression and PWM.
module seg_scan_n
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int FRAME_HZ     = 250,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink_en,
  input  logic                  lz_sup,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [DIGITS-1:0]     sm_wei,
  output logic [7:0]            sm_duan,
  output logic                  frame_done
);
  localparam int DWELL = CLK_HZ / (FRAME_HZ * DIGITS);
  localparam int SLOT  = DWELL >> BRIGHT_W;
  localparam int CW    = SLOT > 1 ? $clog2(SLOT) : 1;
  localparam int IW    = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int BW    = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIGITS-1:0] WEI_ALL = DIGITS'(wei_off(DIGITS));

  logic [CW-1:0]         cyc_q, cyc_d;
  logic [BRIGHT_W-1:0]   slot_q, slot_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  phase_q, phase_d, ph_sh_q, ph_sh_d;
  logic [4*DIGITS-1:0]   data_sh_q, data_sh_d, hi;
  logic [DIGITS-1:0]     dp_sh_q, dp_sh_d, blank_sh_q, blank_sh_d, blink_sh_q, blink_sh_d;
  logic                  lz_sh_q, lz_sh_d;
  logic [BRIGHT_W-1:0]   bright_sh_q, bright_sh_d;
  logic [DIGITS-1:0]     wei_q, wei_d;
  logic [7:0]            duan_q, duan_d;
  logic                  fd_q;
  logic                  cyc_wrap, slot_wrap, start, blink_last, dark;
  logic [6:0]            seg;

  seg_hex_decode u_dec (.nib(hi[3:0]), .seg(seg));

  always_comb begin
    cyc_wrap    = cyc_q == CW'(SLOT - 1);
    slot_wrap   = cyc_wrap && slot_q == '1;
    start       = cyc_q == '0 && slot_q == '0 && idx_q == '0;
    cyc_d       = cyc_wrap ? '0 : cyc_q + 1'b1;
    slot_d      = cyc_wrap ? slot_q + 1'b1 : slot_q;
    idx_d       = !slot_wrap ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
    blink_last  = bcnt_q == BW'(BLINK_FRAMES - 1);
    bcnt_d      = !start ? bcnt_q : blink_last ? '0 : bcnt_q + 1'b1;
    phase_d     = phase_q ^ (start && blink_last);
    // the frame about to start uses the phase held before this frame's toggle
    ph_sh_d     = start ? phase_q : ph_sh_q;
    data_sh_d   = start ? data : data_sh_q;
    dp_sh_d     = start ? dp : dp_sh_q;
    blank_sh_d  = start ? blank : blank_sh_q;
    blink_sh_d  = start ? blink_en : blink_sh_q;
    lz_sh_d     = start ? lz_sup : lz_sh_q;
    bright_sh_d = start ? bright : bright_sh_q;
    hi          = data_sh_d >> (4 * idx_q);
    dark        = blank_sh_d[idx_q] || (blink_sh_d[idx_q] && ph_sh_d) ||
                  (lz_sh_d && idx_q != '0 && hi == '0) || slot_q > bright_sh_d;
    wei_d       = dark ? WEI_ALL : ~(DIGITS'(1) << idx_q);
    duan_d      = dark ? SEG_OFF : {~dp_sh_d[idx_q], seg};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cyc_q       <= '0;
      slot_q      <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      phase_q     <= 1'b0;
      ph_sh_q     <= 1'b0;
      data_sh_q   <= '0;
      dp_sh_q     <= '0;
      blank_sh_q  <= '0;
      blink_sh_q  <= '0;
      lz_sh_q     <= 1'b0;
      bright_sh_q <= '0;
      wei_q       <= WEI_ALL;
      duan_q      <= SEG_OFF;
      fd_q        <= 1'b0;
    end else begin
      cyc_q       <= cyc_d;
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      phase_q     <= phase_d;
      ph_sh_q     <= ph_sh_d;
      data_sh_q   <= data_sh_d;
      dp_sh_q     <= dp_sh_d;
      blank_sh_q  <= blank_sh_d;
      blink_sh_q  <= blink_sh_d;
      lz_sh_q     <= lz_sh_d;
      bright_sh_q <= bright_sh_d;
      wei_q       <= wei_d;
      duan_q      <= duan_d;
      fd_q        <= start;
    end

  assign sm_wei     = wei_q;
  assign sm_duan    = duan_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_n.sv
// tb_seg_scan_n: randomized and directed checks of seg_scan_n against a
// frame-position reference model (4 digits, 16-cycle dwell, 2-frame blink).
module tb_seg_scan_n;
  localparam int DW = 16;
  localparam int FR = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0, blank = '0, blink_en = '0;
  logic        lz_sup = 1'b0;
  logic [2:0]  bright = '0;
  logic [3:0]  sm_wei;
  logic [7:0]  sm_duan;
  logic        frame_done;

  int checks = 0, errors = 0;

  logic [7:0] segt [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  bit          started = 0;
  int          pos = 0, frame = 0;
  logic [15:0] s_data;
  logic [3:0]  s_dp, s_blank, s_blink;
  logic        s_lz;
  logic [2:0]  s_bright;

  seg_scan_n #(.DIGITS(4), .CLK_HZ(6400), .FRAME_HZ(100), .BRIGHT_W(3), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .blank(blank), .blink_en(blink_en),
    .lz_sup(lz_sup), .bright(bright), .sm_wei(sm_wei), .sm_duan(sm_duan), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (!started || pos == FR - 1) begin
      frame = started ? frame + 1 : 0;
      started = 1;
      pos = 0;
      s_data = data; s_dp = dp; s_blank = blank; s_blink = blink_en; s_lz = lz_sup; s_bright = bright;
    end else pos++;
    #1;
  endtask

  task automatic sync();
    while (!started || pos != FR - 1) tick();
  endtask

  function automatic bit lit();
    int d = pos / DW, w = pos % DW;
    if (!started) return 0;
    if (w >= (int'(s_bright) + 1) * 2) return 0;
    if (s_blank[d]) return 0;
    if (s_blink[d] && (frame / 2) % 2 == 1) return 0;
    if (s_lz && d > 0 && (s_data >> (4 * d)) == 16'h0) return 0;
    return 1;
  endfunction

  function automatic logic [3:0] e_wei();
    logic [3:0] m = 4'b0001;
    return lit() ? ~(m << (pos / DW)) : 4'hF;
  endfunction

  function automatic logic [7:0] e_duan();
    logic [7:0] e;
    int d = pos / DW;
    e = segt[(s_data >> (4 * d)) & 16'hF];
    e[7] = ~s_dp[d];
    return lit() ? e : 8'hFF;
  endfunction

  function automatic logic e_fd();
    return started && pos == 0;
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sm_wei !== 4'hF || sm_duan !== 8'hFF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state wei=%b duan=%h fd=%b want 1111 ff 0", sm_wei, sm_duan, frame_done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (sm_wei !== 4'hF || sm_duan !== 8'hFF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release wei=%b duan=%h fd=%b want 1111 ff 0", sm_wei, sm_duan, frame_done);
    end
  endtask

  task automatic test_basic();
    logic [3:0] kw [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] kd [4] = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
    data = 16'h12AF; bright = 3'd7; dp = '0; blank = '0; blink_en = '0; lz_sup = 0;
    sync();
    repeat (2 * FR) begin
      tick();
      checks++;
      if ({sm_wei, sm_duan, frame_done} !== {e_wei(), e_duan(), e_fd()}) begin
        errors++;
        $display("FAIL basic pos=%0d wei=%b/%b duan=%h/%h fd=%b/%b", pos, sm_wei, e_wei(), sm_duan, e_duan(), frame_done, e_fd());
      end
      if (pos % DW == 5) begin
        checks++;
        if (sm_wei !== kw[pos / DW] || sm_duan !== kd[pos / DW]) begin
          errors++;
          $display("FAIL basic_table pos=%0d wei=%b duan=%h want %b %h", pos, sm_wei, sm_duan, kw[pos / DW], kd[pos / DW]);
        end
      end
    end
  endtask

  task automatic test_bright();
    int low [4];
    bright = 3'd1;
    sync();
    low = '{0, 0, 0, 0};
    repeat (FR) begin
      tick();
      for (int d = 0; d < 4; d++) if (!sm_wei[d]) low[d]++;
      checks++;
      if ({sm_wei, sm_duan, frame_done} !== {e_wei(), e_duan(), e_fd()}) begin
        errors++;
        $display("FAIL bright pos=%0d wei=%b/%b duan=%h/%h fd=%b/%b", pos, sm_wei, e_wei(), sm_duan, e_duan(), frame_done, e_fd());
      end
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (low[d] != 4) begin
        errors++;
        $display("FAIL bright_duty digit=%0d low_cycles=%0d want 4", d, low[d]);
      end
    end
  endtask

  task automatic test_lz();
    data = 16'h0040; lz_sup = 1; dp = 4'b1000; bright = 3'd7;
    sync();
    repeat (FR) begin
      tick();
      checks++;
      if ({sm_wei, sm_duan, frame_done} !== {e_wei(), e_duan(), e_fd()}) begin
        errors++;
        $display("FAIL lz pos=%0d wei=%b/%b duan=%h/%h fd=%b/%b", pos, sm_wei, e_wei(), sm_duan, e_duan(), frame_done, e_fd());
      end
      if (pos == 20 || pos == 3 || pos == 40) begin
        checks++;
        if (sm_duan !== (pos == 20 ? 8'h99 : pos == 3 ? 8'hC0 : 8'hFF)) begin
          errors++;
          $display("FAIL lz_table pos=%0d duan=%h", pos, sm_duan);
        end
      end
    end
    lz_sup = 0; dp = '0;
  endtask

  task automatic test_blink();
    data = 16'h5678; blink_en = 4'b0001; bright = 3'd7;
    sync();
    repeat (5 * FR) begin
      tick();
      checks++;
      if ({sm_wei, sm_duan, frame_done} !== {e_wei(), e_duan(), e_fd()}) begin
        errors++;
        $display("FAIL blink frame=%0d pos=%0d wei=%b/%b duan=%h/%h", frame, pos, sm_wei, e_wei(), sm_duan, e_duan());
      end
    end
    blink_en = '0;
  endtask

  task automatic test_midframe();
    data = 16'h1111; bright = 3'd7;
    sync();
    repeat (2 * FR) begin
      tick();
      if (pos == 20 && data == 16'h1111) data = 16'h2222;
      checks++;
      if ({sm_wei, sm_duan, frame_done} !== {e_wei(), e_duan(), e_fd()}) begin
        errors++;
        $display("FAIL midframe pos=%0d wei=%b/%b duan=%h/%h", pos, sm_wei, e_wei(), sm_duan, e_duan());
      end
      if (pos == 40) begin
        checks++;
        if (sm_duan !== (s_data == 16'h1111 ? 8'hF9 : 8'hA4)) begin
          errors++;
          $display("FAIL midframe_val duan=%h snap=%h", sm_duan, s_data);
        end
      end
    end
  endtask

  task automatic test_random();
    repeat (10 * FR) begin
      if ($urandom_range(7) == 0) begin
        data = 16'($urandom); dp = 4'($urandom); blank = 4'($urandom & $urandom);
        blink_en = 4'($urandom); lz_sup = 1'($urandom); bright = 3'($urandom);
        if ($urandom_range(1) == 0) data[15:8] = '0;
      end
      tick();
      checks++;
      if ({sm_wei, sm_duan, frame_done} !== {e_wei(), e_duan(), e_fd()}) begin
        errors++;
        $display("FAIL random frame=%0d pos=%0d wei=%b/%b duan=%h/%h fd=%b/%b", frame, pos, sm_wei, e_wei(), sm_duan, e_duan(), frame_done, e_fd());
      end
    end
  endtask

  task automatic test_reset_mid();
    data = 16'h4321; dp = '0; blank = '0; blink_en = '0; lz_sup = 0; bright = 3'd7;
    sync();
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sm_wei !== 4'hF || sm_duan !== 8'hFF) begin
      errors++;
      $display("FAIL reset_mid_dark wei=%b duan=%h want 1111 ff", sm_wei, sm_duan);
    end
    started = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (sm_wei !== 4'b1110 || sm_duan !== 8'hF9 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL reset_restart wei=%b duan=%h fd=%b want 1110 f9 1", sm_wei, sm_duan, frame_done);
    end
    repeat (FR + 8) begin
      tick();
      checks++;
      if ({sm_wei, sm_duan, frame_done} !== {e_wei(), e_duan(), e_fd()}) begin
        errors++;
        $display("FAIL reset_mid pos=%0d wei=%b/%b duan=%h/%h", pos, sm_wei, e_wei(), sm_duan, e_duan());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bright();
    test_lz();
    test_blink();
    test_midframe();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_n.md
# seg_scan_n

Parametrised, time-multiplexed driver for common-anode 7-segment displays: N digits, full hex decode, decimal points, per-digit blanking and blinking, leading-zero suppression and PWM brightness. It sits between the datapath (which presents packed BCD/hex nibbles) and the board display pins. It replaces the fixed 4-digit scanner and adds a registered, tear-free frame snapshot.

## Interface
- DIGITS, 4: number of digits scanned (1..8).
- CLK_HZ, 100_000_000: clk frequency.
- FRAME_HZ, 250: full-frame refresh rate; dwell per digit DWELL = CLK_HZ/(FRAME_HZ*DIGITS).
- BRIGHT_W, 3: brightness width; DWELL must be a multiple of 2**BRIGHT_W, giving SLOT = DWELL/2**BRIGHT_W ≥ 1.
- BLINK_FRAMES, 125: frames per blink half-period.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- data  in  4*DIGITS  nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant.
- dp  in  DIGITS  decimal point on per digit.
- blank  in  DIGITS  force digit dark.
- blink_en  in  DIGITS  digit dark during blink-off phase.
- lz_sup  in  1  leading-zero suppression enable.
- bright  in  BRIGHT_W  on-time: (bright+1)/2**BRIGHT_W of each dwell.
- sm_wei  out  DIGITS  digit enables, active-low, at most one bit low.
- sm_duan  out  8  segments active-low, bit7 = dp, bits6:0 = g..a.
- frame_done  out  1  one-cycle pulse at each frame start.

## Operation
- Counters: cyc (0..SLOT-1), slot (0..2**BRIGHT_W-1), idx (0..DIGITS-1). cyc wraps → slot++; slot wraps → idx++; idx wraps DIGITS-1→0 = frame start.
- Frame start: snapshot data, dp, blank, blink_en, lz_sup, bright into shadow registers; pulse frame_done; blink frame counter increments, toggling blink phase on reaching BLINK_FRAMES-1 (counter then 0). Inputs changing mid-frame have no effect until next frame start.
- Digit dark if: blank[idx]; or blink_en[idx] and phase=1; or suppressed; or slot > bright (shadow).
- Suppression (lz_sup=1): digit i>0 suppressed when nibbles i..DIGITS-1 are all zero; digit 0 never suppressed. Suppressed digit's dp is also dark.
- Lit digit: sm_wei = all ones except bit idx low; sm_duan = {~dp[idx], hex segment code of nibble}. Dark digit: sm_wei all ones, sm_duan 8'hFF.
- Hex codes a..g active-low: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E (bit7 shown as 1).

## Timing
- Reset (asynchronous assert, synchronous-safe release): cyc=slot=idx=0, phase=0, blink counter 0, shadows 0, sm_wei all ones, sm_duan 8'hFF, frame_done 0.
- First frame start occurs on the first clock edge after reset release (shadows loaded then); display content appears one cycle later.
- sm_wei, sm_duan, frame_done are registered: they reflect counter/shadow state with 1-cycle latency.
- Digit i is enabled for (bright+1)*SLOT consecutive cycles starting at its dwell start; dark for the remainder. bright all ones → 100% duty.
- Full frame = DIGITS*DWELL cycles; frame_done period identical; blink period 2*BLINK_FRAMES frames.
- Reset mid-frame: outputs go dark immediately (asynchronous), scan restarts at digit 0.

## Structure
- Package seg_pkg: 16-entry hex segment lookup constant, SEG_OFF = 8'hFF, WEI_OFF helper for DIGITS-wide all-ones.
- Sub-module seg_hex_decode: combinational nibble→7-bit segment code using the package table.
- Top holds counters, snapshot registers, suppression/blink logic, output registers.

## Test plan
Bench parameters: DIGITS=4, CLK_HZ=6400, FRAME_HZ=100 (DWELL=16), BRIGHT_W=3 (SLOT=2), BLINK_FRAMES=2.
- data=16'h12AF, bright=7, others 0 → per 16-cycle dwell: wei 1110/duan 8E, 1101/88, 1011/A4, 0111/F9; frame_done every 64 cycles.
- bright=1 → each digit low on sm_wei for exactly 4 cycles then 12 cycles all ones.
- data=16'h0040, lz_sup=1, dp=4'b1000 → digits 3,2 dark (dp also dark); digit1 duan 99; digit0 duan C0.
- blink_en=4'b0001 → digit 0 lit frames 0-1, dark frames 2-3, repeat; other digits always lit.
- data changed mid-frame from 16'h1111 to 16'h2222 → remainder of frame shows 1, next frame shows 2.
- rst_n low mid-dwell → same cycle sm_wei=1111, sm_duan=FF; after release scanning restarts at digit 0.
